// File: rtl/lfsr_count_pkg.sv
// Shared definitions for the LFSR counter controller: command opcodes,
// FSM state encoding and the 6-bit LFSR step-index decode function.
package lfsr_count_pkg;

   // Command opcodes carried on cmd_op
   localparam logic [1:0] OP_START = 2'd0;
   localparam logic [1:0] OP_STOP  = 2'd1;
   localparam logic [1:0] OP_CLEAR = 2'd2;
   localparam logic [1:0] OP_SNAP  = 2'd3;

   // Controller FSM encoding, also exported on the debug state port
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_CLR  = 2'd2,
      ST_SNAP = 2'd3
   } state_t;

   // LFSR field sequence starts here and visits all 63 non-zero values
   localparam logic [5:0] LFSR_SEED  = 6'h3F;
   localparam int         LFSR_STEPS = 63;

   // One LFSR step: bit0 <= bit5, bitN <= bitN-1, bit5 <= bit4 ^ bit5
   function automatic logic [5:0] lfsr6_next(input logic [5:0] s);
      return {s[4] ^ s[5], s[3:0], s[5]};
   endfunction

   // Step index (0..62) of an LFSR value counted from the seed.
   // The all-zero value never occurs in the sequence and maps to 6'h3F.
   function automatic logic [5:0] lfsr6_index(input logic [5:0] v);
      logic [5:0] s;
      logic [5:0] idx;
      s   = LFSR_SEED;
      idx = 6'h3F;
      for (int i = 0; i < LFSR_STEPS; i++) begin
         if (s == v) idx = 6'(i);
         s = lfsr6_next(s);
      end
      return idx;
   endfunction

endpackage

// File: rtl/lfsr_count_ctrl_decode.sv
// lfsr6_decode: combinational translation of the raw 6-bit LFSR field into
// its binary step index. Flags the all-zero field, which is not a legal
// LFSR state. Only instantiated when LFSR_SNAP_DECODE_EN is defined.
module lfsr6_decode
   import lfsr_count_pkg::*;
(
   input  logic [5:0] field,
   output logic [5:0] index,
   output logic       invalid
);

   assign index   = lfsr6_index(field);
   assign invalid = (field == 6'h00);

endmodule

// File: rtl/lfsr_count_ctrl.sv
// lfsr_count_ctrl: command-driven controller for an external LFSR-based
// counter. Accepts START/STOP/CLEAR/SNAP commands, drives the counter's
// enable and clear, and offers captured counts on a snapshot channel.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high; valid, once raised, and its data stay stable until
// that transfer. cmd_ready is registered and drops in CLR and SNAP.
//
// Build option: define LFSR_SNAP_DECODE_EN to replace snap_data[5:0] with
// the decoded LFSR step index (requires CNT_W > 6). Default: raw capture.
module lfsr_count_ctrl
   import lfsr_count_pkg::*;
#(
   parameter int CLR_CYCLES = 2,
   parameter int CNT_W      = 64
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   output logic             cmd_ready,
   output logic             cnt_en,
   output logic             cnt_clr,
   input  logic [CNT_W-1:0] cnt_q,
   output logic             snap_valid,
   input  logic             snap_ready,
   output logic [CNT_W-1:0] snap_data,
   output logic             cmd_err,
   output state_t           dbg_state
);

   // Hold counter preload: counts CLR_CYCLES-1 down to 0 inclusive
   localparam logic [3:0] CLR_LOAD = 4'(CLR_CYCLES - 1);

   state_t           state;
   logic             run_flag;
   logic [3:0]       clr_cnt;
   logic             cmd_accept;
   logic [CNT_W-1:0] snap_capture;
   logic             snap_err;

   assign cmd_accept = cmd_valid & cmd_ready;
   assign dbg_state  = state;

`ifdef LFSR_SNAP_DECODE_EN
   logic [5:0] dec_index;
   logic       dec_invalid;

   lfsr6_decode u_decode (
      .field   (cnt_q[5:0]),
      .index   (dec_index),
      .invalid (dec_invalid)
   );

   assign snap_capture = {cnt_q[CNT_W-1:6], dec_index};
   assign snap_err     = dec_invalid;
`else
   assign snap_capture = cnt_q;
   assign snap_err     = 1'b0;
`endif

   // Controller FSM with every output registered; commands act one cycle after acceptance
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state      <= ST_IDLE;
         run_flag   <= 1'b0;
         clr_cnt    <= '0;
         cmd_ready  <= 1'b1;
         cnt_en     <= 1'b0;
         cnt_clr    <= 1'b1;
         cmd_err    <= 1'b0;
         snap_valid <= 1'b0;
         snap_data  <= '0;
      end else begin
         cmd_err <= 1'b0;
         case (state)
            ST_IDLE, ST_RUN: begin
               cnt_clr <= 1'b0;
               if (cmd_accept) begin
                  case (cmd_op)
                     OP_START: begin
                        if (state == ST_IDLE) begin
                           state    <= ST_RUN;
                           run_flag <= 1'b1;
                           cnt_en   <= 1'b1;
                        end else begin
                           cmd_err  <= 1'b1;
                        end
                     end
                     OP_STOP: begin
                        if (state == ST_RUN) begin
                           state    <= ST_IDLE;
                           run_flag <= 1'b0;
                           cnt_en   <= 1'b0;
                        end else begin
                           cmd_err  <= 1'b1;
                        end
                     end
                     OP_CLEAR: begin
                        state     <= ST_CLR;
                        clr_cnt   <= CLR_LOAD;
                        cnt_clr   <= 1'b1;
                        cnt_en    <= 1'b0;
                        cmd_ready <= 1'b0;
                     end
                     default: begin
                        state      <= ST_SNAP;
                        snap_data  <= snap_capture;
                        snap_valid <= 1'b1;
                        cmd_ready  <= 1'b0;
                        cmd_err    <= snap_err;
                     end
                  endcase
               end
            end
            ST_CLR: begin
               // The counter saturates at zero, so it cannot wrap into a longer hold
               if (clr_cnt == 4'd0) begin
                  state     <= ST_IDLE;
                  run_flag  <= 1'b0;
                  cnt_en    <= 1'b0;
                  cnt_clr   <= 1'b0;
                  cmd_ready <= 1'b1;
               end else begin
                  clr_cnt   <= clr_cnt - 4'd1;
               end
            end
            ST_SNAP: begin
               // run_flag is left alone so a running counter keeps counting
               if (snap_ready) begin
                  state      <= run_flag ? ST_RUN : ST_IDLE;
                  snap_valid <= 1'b0;
                  cmd_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               run_flag  <= 1'b0;
               cnt_en    <= 1'b0;
               cnt_clr   <= 1'b0;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_count_ctrl.sv
// Directed self-checking bench for lfsr_count_ctrl (CLR_CYCLES = 3).
// Works for both the raw build and the LFSR_SNAP_DECODE_EN build.
module tb_lfsr_count_ctrl;
   import lfsr_count_pkg::*;

   localparam int CNT_W = 64;

   logic             clk = 1'b0;
   logic             nrst;
   logic             cmd_valid;
   logic [1:0]       cmd_op;
   logic             cmd_ready;
   logic             cnt_en;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_q;
   logic             snap_valid;
   logic             snap_ready;
   logic [CNT_W-1:0] snap_data;
   logic             cmd_err;
   state_t           dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   logic [CNT_W-1:0] exp_snap;
   logic             exp_zero_err;

   lfsr_count_ctrl #(.CLR_CYCLES(3), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .cmd_valid  (cmd_valid),
      .cmd_op     (cmd_op),
      .cmd_ready  (cmd_ready),
      .cnt_en     (cnt_en),
      .cnt_clr    (cnt_clr),
      .cnt_q      (cnt_q),
      .snap_valid (snap_valid),
      .snap_ready (snap_ready),
      .snap_data  (snap_data),
      .cmd_err    (cmd_err),
      .dbg_state  (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // present one command for exactly one cycle (cmd_ready is high in IDLE/RUN)
   task automatic send(input logic [1:0] op);
      cmd_valid = 1'b1;
      cmd_op    = op;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      nrst       = 1'b0;
      cmd_valid  = 1'b0;
      cmd_op     = OP_START;
      cnt_q      = '0;
      snap_ready = 1'b0;

      // ---- reset ----
      tick();
      tick();
      chk("rst_cnt_en",     64'(cnt_en), 64'd0);
      chk("rst_cnt_clr",    64'(cnt_clr), 64'd1);
      chk("rst_cmd_err",    64'(cmd_err), 64'd0);
      chk("rst_snap_valid", 64'(snap_valid), 64'd0);
      chk("rst_snap_data",  snap_data, 64'd0);
      chk("rst_state",      64'(dbg_state), 64'(ST_IDLE));

      nrst = 1'b1;
      tick();
      chk("rel_cnt_clr",   64'(cnt_clr), 64'd0);
      chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rel_cnt_en",    64'(cnt_en), 64'd0);

      // ---- START: cnt_en exactly one cycle after acceptance ----
      cmd_valid = 1'b1;
      cmd_op    = OP_START;
      chk("start_acc_cnt_en", 64'(cnt_en), 64'd0);
      tick();
      cmd_valid = 1'b0;
      chk("start_cnt_en", 64'(cnt_en), 64'd1);
      chk("start_state",  64'(dbg_state), 64'(ST_RUN));

      // ---- SNAP in RUN, field 3F, held 5 cycles ----
      cnt_q = 64'h1234_5678_9ABC_DE3F;
`ifdef LFSR_SNAP_DECODE_EN
      exp_snap = 64'h1234_5678_9ABC_DE00;
`else
      exp_snap = 64'h1234_5678_9ABC_DE3F;
`endif
      send(OP_SNAP);
      cnt_q = 64'hFFFF_0000_FFFF_0001;
      chk("snap1_valid",     64'(snap_valid), 64'd1);
      chk("snap1_data",      snap_data, exp_snap);
      chk("snap1_state",     64'(dbg_state), 64'(ST_SNAP));
      chk("snap1_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("snap1_cmd_err",   64'(cmd_err), 64'd0);
      // a STOP offered while not ready must be ignored
      cmd_valid = 1'b1;
      cmd_op    = OP_STOP;
      for (int i = 0; i < 5; i++) begin
         cnt_q = cnt_q + 64'h0101_0101_0101_0103;
         tick();
         chk("snap_hold_data",  snap_data, exp_snap);
         chk("snap_hold_valid", 64'(snap_valid), 64'd1);
         chk("snap_hold_en",    64'(cnt_en), 64'd1);
         chk("snap_hold_ready", 64'(cmd_ready), 64'd0);
         chk("snap_hold_state", 64'(dbg_state), 64'(ST_SNAP));
      end
      cmd_valid  = 1'b0;
      snap_ready = 1'b1;
      tick();
      snap_ready = 1'b0;
      chk("snap1_done_valid", 64'(snap_valid), 64'd0);
      chk("snap1_done_state", 64'(dbg_state), 64'(ST_RUN));
      chk("snap1_done_ready", 64'(cmd_ready), 64'd1);
      chk("snap1_done_en",    64'(cnt_en), 64'd1);

      // ---- SNAP in RUN, field 1F (step 1) ----
      cnt_q = 64'h0000_0000_0000_005F;
`ifdef LFSR_SNAP_DECODE_EN
      exp_snap = 64'h0000_0000_0000_0041;
`else
      exp_snap = 64'h0000_0000_0000_005F;
`endif
      send(OP_SNAP);
      chk("snap2_data", snap_data, exp_snap);
      snap_ready = 1'b1;
      tick();
      snap_ready = 1'b0;
      chk("snap2_done_state", 64'(dbg_state), 64'(ST_RUN));

      // ---- START in RUN: illegal, single-cycle cmd_err ----
      send(OP_START);
      chk("start_run_err",   64'(cmd_err), 64'd1);
      chk("start_run_state", 64'(dbg_state), 64'(ST_RUN));
      tick();
      chk("start_run_err_off", 64'(cmd_err), 64'd0);

      // ---- CLEAR in RUN: cnt_clr for exactly 3 cycles ----
      send(OP_CLEAR);
      for (int i = 0; i < 3; i++) begin
         chk("clr_cnt_clr",   64'(cnt_clr), 64'd1);
         chk("clr_cnt_en",    64'(cnt_en), 64'd0);
         chk("clr_cmd_ready", 64'(cmd_ready), 64'd0);
         chk("clr_state",     64'(dbg_state), 64'(ST_CLR));
         tick();
      end
      chk("clr_done_cnt_clr", 64'(cnt_clr), 64'd0);
      chk("clr_done_state",   64'(dbg_state), 64'(ST_IDLE));
      chk("clr_done_cnt_en",  64'(cnt_en), 64'd0);
      chk("clr_done_ready",   64'(cmd_ready), 64'd1);

      // ---- STOP in IDLE: illegal, single-cycle cmd_err ----
      send(OP_STOP);
      chk("stop_idle_err",   64'(cmd_err), 64'd1);
      chk("stop_idle_state", 64'(dbg_state), 64'(ST_IDLE));
      tick();
      chk("stop_idle_err_off",   64'(cmd_err), 64'd0);
      chk("stop_idle_state_2",   64'(dbg_state), 64'(ST_IDLE));

      // ---- SNAP in IDLE with illegal LFSR field 00 ----
      cnt_q = 64'hABCD_0000_0000_1240;
`ifdef LFSR_SNAP_DECODE_EN
      exp_snap     = 64'hABCD_0000_0000_127F;
      exp_zero_err = 1'b1;
`else
      exp_snap     = 64'hABCD_0000_0000_1240;
      exp_zero_err = 1'b0;
`endif
      send(OP_SNAP);
      chk("snap0_data",    snap_data, exp_snap);
      chk("snap0_cmd_err", 64'(cmd_err), 64'(exp_zero_err));
      chk("snap0_cnt_en",  64'(cnt_en), 64'd0);
      snap_ready = 1'b1;
      tick();
      snap_ready = 1'b0;
      chk("snap0_done_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("snap0_done_err",   64'(cmd_err), 64'd0);

      // ---- SNAP with field 3E (step 2) ----
      cnt_q = 64'h0000_0000_0000_013E;
`ifdef LFSR_SNAP_DECODE_EN
      exp_snap = 64'h0000_0000_0000_0102;
`else
      exp_snap = 64'h0000_0000_0000_013E;
`endif
      send(OP_SNAP);
      chk("snap3_data", snap_data, exp_snap);

      // ---- reset mid-SNAP discards the snapshot ----
      nrst = 1'b0;
      tick();
      chk("rst_snap_valid_2", 64'(snap_valid), 64'd0);
      chk("rst_snap_state",   64'(dbg_state), 64'(ST_IDLE));
      chk("rst_snap_data_2",  snap_data, 64'd0);
      chk("rst_snap_clr",     64'(cnt_clr), 64'd1);
      nrst = 1'b1;
      tick();
      chk("rst_snap_rel_clr", 64'(cnt_clr), 64'd0);

      // ---- reset mid-CLR abandons the clear ----
      send(OP_CLEAR);
      chk("clr2_state", 64'(dbg_state), 64'(ST_CLR));
      nrst = 1'b0;
      tick();
      chk("rst_clr_state", 64'(dbg_state), 64'(ST_IDLE));
      nrst = 1'b1;
      tick();
      chk("rst_clr_rel_clr",   64'(cnt_clr), 64'd0);
      chk("rst_clr_rel_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("rst_clr_rel_ready", 64'(cmd_ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lfsr_count_ctrl.md
LFSR_COUNT_CTRL -- requirements
Module: lfsr_count_ctrl

Interface
REQ-001 The block SHALL have parameter CLR_CYCLES, default 2: number of cycles cnt_clr is held asserted per CLEAR (legal 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 64: counter and snapshot width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port nrst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-006 The block SHALL have port cmd_op, input, 2 bits: 0 START, 1 STOP, 2 CLEAR, 3 SNAP.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high.
REQ-008 The block SHALL have port cnt_en, output, 1 bit: drives the counter count-enable input.
REQ-009 The block SHALL have port cnt_clr, output, 1 bit: active-high counter reset.
REQ-010 The block SHALL have port cnt_q, input, CNT_W bits: counter value; bits [5:0] are the raw LFSR field.
REQ-011 The block SHALL have port snap_valid, output, 1 bit: snapshot available.
REQ-012 The block SHALL have port snap_ready, input, 1 bit: snapshot consumed when snap_valid and snap_ready are both high.
REQ-013 The block SHALL have port snap_data, output, CNT_W bits: captured count.
REQ-014 The block SHALL have port cmd_err, output, 1 bit: one-cycle pulse on an accepted illegal command.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, CLR and SNAP, plus a run_flag register that records run intent.
REQ-016 cnt_en SHALL equal run_flag in every state except CLR, where it SHALL be 0.
REQ-017 cmd_ready SHALL be 1 in IDLE and RUN, and 0 in CLR and SNAP.
REQ-018 START accepted in IDLE SHALL transition to RUN with run_flag=1, and cnt_en SHALL be 1 from the next cycle.
REQ-019 STOP accepted in RUN SHALL transition to IDLE with run_flag=0, and cnt_en SHALL be 0 from the next cycle.
REQ-020 START in RUN or STOP in IDLE SHALL be accepted, cause no state change, and pulse cmd_err for one cycle.
REQ-021 CLEAR accepted in IDLE or RUN SHALL enter CLR, assert cnt_clr for exactly CLR_CYCLES cycles, then enter IDLE with run_flag=0.
REQ-022 SNAP SHALL register cnt_q sampled in the acceptance cycle into snap_data and enter SNAP with snap_valid=1 the next cycle.
REQ-023 In SNAP, run_flag SHALL be unchanged, so a running counter keeps counting.
REQ-024 snap_data and snap_valid SHALL be held stable until snap_ready=1, after which the FSM SHALL return to RUN if run_flag=1, else IDLE, with snap_valid=0 the next cycle.
REQ-025 The CLR hold counter SHALL be 4 bits and SHALL not wrap; it SHALL reload on every CLR entry.
REQ-026 The block SHALL have no fall-through: an accepted command SHALL take effect on outputs one cycle after acceptance.

Reset
REQ-027 While nrst=0 at a clock edge, state SHALL become IDLE, run_flag=0, cnt_en=0 and cmd_err=0.
REQ-028 While nrst=0 at a clock edge, snap_valid=0 and snap_data=0.
REQ-029 While nrst=0, cnt_clr SHALL be 1 so the counter is reset together with the controller; cnt_clr SHALL return to 0 the first cycle after nrst=1.
REQ-030 Reset asserted mid-CLR or mid-SNAP SHALL abandon the operation and discard any pending snapshot.

Configuration
REQ-031 With macro LFSR_SNAP_DECODE_EN defined, snap_data[5:0] SHALL hold the binary step index (0..62) of the captured LFSR field, counted from seed 6'h3F under the next-state rule bit0<=bit5, bitN<=bitN-1 (N=1..4), bit5<=bit4^bit5.
REQ-032 With LFSR_SNAP_DECODE_EN defined, LFSR field 6'h00 SHALL decode to 6'h3F and pulse cmd_err.
REQ-033 Without LFSR_SNAP_DECODE_EN, snap_data SHALL equal the raw cnt_q.

Structure
REQ-034 A shared package lfsr_count_pkg SHALL hold the opcode constants, the FSM state encoding and the 63-entry LFSR-to-index decode function.
REQ-035 The decoder SHALL be one sub-module, lfsr6_decode, instantiated only when LFSR_SNAP_DECODE_EN is defined.

Verification
REQ-036 Reset then START: the bench SHALL check cnt_en=0 and cnt_clr=1 during reset, cnt_clr=0 after release, and cnt_en=1 exactly one cycle after START acceptance.
REQ-037 RUN then SNAP with snap_ready=0 for 5 cycles: the bench SHALL check snap_data constant, cnt_en still 1 and cmd_ready=0, then return to RUN after snap_ready.
REQ-038 CLEAR in RUN with CLR_CYCLES=3: the bench SHALL check cnt_clr high for exactly 3 cycles, cnt_en=0 throughout, then IDLE with cnt_en=0.
REQ-039 STOP in IDLE: the bench SHALL check cmd_err is a single-cycle pulse and the state stays IDLE.
REQ-040 Decode build with cnt_q[5:0]=6'h3F then 6'h1F: the bench SHALL check snap_data[5:0]=0 then 1; raw build: snap_data=cnt_q.
REQ-041 nrst=0 asserted mid-SNAP: the bench SHALL check snap_valid=0, state IDLE and snap_data=0 the next cycle.
